// File: rtl/placar_pkg.sv
// Shared scoreboard definitions: FSM encoding, BCD time record and limits,
// and the quarter-start load value helper.
package placar_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] DIGIT_MAX_9 = BCD_W'(9);
  localparam logic [BCD_W-1:0] DIGIT_MAX_5 = BCD_W'(5);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    BUZZ  = 3'd3,
    BREAK = 3'd4,
    OVER  = 3'd5
  } state_t;

  typedef struct packed {
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
  } bcd_time_t;

  function automatic bcd_time_t load_time(input int unsigned minutes);
    bcd_time_t t;
    t.min_tens = BCD_W'(minutes / 10);
    t.min_ones = BCD_W'(minutes % 10);
    t.sec_tens = '0;
    t.sec_ones = '0;
    return t;
  endfunction

endpackage

// File: rtl/game_timer_ctrl_if.sv
// Button/divider inputs and display/buzzer outputs of the game timer.
interface game_timer_ctrl_if;
  import placar_pkg::*;

  logic             tick_src;
  logic             start_pause;
  logic [BCD_W-1:0] min_tens;
  logic [BCD_W-1:0] min_ones;
  logic [BCD_W-1:0] sec_tens;
  logic [BCD_W-1:0] sec_ones;
  logic [2:0]       quarter;
  logic             running;
  logic             buzzer;
  logic             game_over;

  modport master (
    output tick_src, start_pause,
    input  min_tens, min_ones, sec_tens, sec_ones, quarter, running, buzzer, game_over
  );

  modport slave (
    input  tick_src, start_pause,
    output min_tens, min_ones, sec_tens, sec_ones, quarter, running, buzzer, game_over
  );

endinterface

// File: rtl/game_timer_ctrl_tick_pulse.sv
// Rising-edge detector for a slow, already-synchronous divider tap.
module tick_pulse #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // NOTE: resetting the history to 1 means a level already high at reset
  // release is not mistaken for a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= RST_VAL;
    else        level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/game_timer_ctrl.sv
// Scoreboard game clock: per-quarter BCD countdown, start/pause, quarter
// sequencing and end-of-quarter buzzer. Single clock domain.
module game_timer_ctrl
  import placar_pkg::*;
#(
  parameter int QUARTER_MIN  = 10,  // 1..99
  parameter int NUM_QUARTERS = 4,   // 1..7
  parameter int BUZZ_TICKS   = 3
) (
  input  logic              clock_in,
  input  logic              reset_n,
  game_timer_ctrl_if.slave  bus
);

  localparam bcd_time_t LOAD_TIME = load_time(QUARTER_MIN);
  localparam bcd_time_t LAST_SEC  = '{min_tens: '0, min_ones: '0,
                                      sec_tens: '0, sec_ones: BCD_W'(1)};
  localparam int        BUZZ_W    = (BUZZ_TICKS > 1) ? $clog2(BUZZ_TICKS) : 1;
  localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_TICKS - 1);
  localparam logic [2:0]        LAST_Q    = 3'(NUM_QUARTERS);

  state_t            state;
  bcd_time_t         time_q;
  bcd_time_t         time_dec;
  logic [2:0]        quarter_q;
  logic [BUZZ_W-1:0] buzz_cnt;
  logic              running_q;
  logic              buzzer_q;
  logic              game_over_q;
  logic              tick;

  tick_pulse #(.RST_VAL(1'b1)) u_tick (
    .clk   (clock_in),
    .rst_n (reset_n),
    .level (bus.tick_src),
    .pulse (tick)
  );

  // One-second decrement with a per-digit borrow chain.
  // NOTE: time_dec is given a full default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    time_dec = time_q;
    if (time_q.sec_ones != '0) begin
      time_dec.sec_ones = time_q.sec_ones - BCD_W'(1);
    end else begin
      time_dec.sec_ones = DIGIT_MAX_9;
      if (time_q.sec_tens != '0) begin
        time_dec.sec_tens = time_q.sec_tens - BCD_W'(1);
      end else begin
        time_dec.sec_tens = DIGIT_MAX_5;
        if (time_q.min_ones != '0) begin
          time_dec.min_ones = time_q.min_ones - BCD_W'(1);
        end else begin
          time_dec.min_ones = DIGIT_MAX_9;
          time_dec.min_tens = time_q.min_tens - BCD_W'(1);
        end
      end
    end
  end

  // Status flags are set on the transition itself so they are registered
  // alongside the state rather than decoded from it.
  // NOTE: all state here uses non-blocking assignment so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      time_q      <= LOAD_TIME;
      quarter_q   <= 3'd1;
      buzz_cnt    <= '0;
      running_q   <= 1'b0;
      buzzer_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_pause) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.start_pause) begin
            state     <= PAUSE;
            running_q <= 1'b0;
          end else if (tick) begin
            time_q <= time_dec;
            if (time_q == LAST_SEC) begin
              state     <= BUZZ;
              running_q <= 1'b0;
              buzzer_q  <= 1'b1;
              buzz_cnt  <= '0;
            end
          end
        end
        PAUSE: begin
          if (bus.start_pause) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        BUZZ: begin
          if (tick) begin
            if (buzz_cnt == BUZZ_LAST) begin
              buzzer_q <= 1'b0;
              if (quarter_q == LAST_Q) begin
                state       <= OVER;
                game_over_q <= 1'b1;
              end else begin
                state <= BREAK;
              end
            end else begin
              buzz_cnt <= buzz_cnt + BUZZ_W'(1);
            end
          end
        end
        BREAK: begin
          if (bus.start_pause) begin
            time_q    <= LOAD_TIME;
            quarter_q <= quarter_q + 3'd1;
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        OVER: begin
        end
        default: begin
          state       <= IDLE;
          time_q      <= LOAD_TIME;
          quarter_q   <= 3'd1;
          running_q   <= 1'b0;
          buzzer_q    <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.min_tens  = time_q.min_tens;
  assign bus.min_ones  = time_q.min_ones;
  assign bus.sec_tens  = time_q.sec_tens;
  assign bus.sec_ones  = time_q.sec_ones;
  assign bus.quarter   = quarter_q;
  assign bus.running   = running_q;
  assign bus.buzzer    = buzzer_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl: directed scenarios plus random
// tick/start streams compared against a seconds-based reference model.
module tb_game_timer_ctrl;
  import placar_pkg::*;

  localparam int QM   = 1;
  localparam int NQ   = 2;
  localparam int BT   = 3;
  localparam int QM10 = 10;

  localparam int P_IDLE = 0, P_RUN = 1, P_PAUSE = 2, P_BUZZ = 3, P_BREAK = 4, P_OVER = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  game_timer_ctrl_if ifc ();
  game_timer_ctrl_if ifc10 ();

  game_timer_ctrl #(.QUARTER_MIN(QM), .NUM_QUARTERS(NQ), .BUZZ_TICKS(BT)) dut (
    .clock_in (clk),
    .reset_n  (rst_n),
    .bus      (ifc.slave)
  );

  game_timer_ctrl #(.QUARTER_MIN(QM10), .NUM_QUARTERS(NQ), .BUZZ_TICKS(BT)) dut10 (
    .clock_in (clk),
    .reset_n  (rst_n),
    .bus      (ifc10.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining seconds, quarter, phase, ticks spent buzzing.
  int m_phase, m_rem, m_q, m_buzz;
  int m10;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int rem);
    int m, s;
    m = rem / 60;
    s = rem % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] shown(input int unused);
    return {ifc.min_tens, ifc.min_ones, ifc.sec_tens, ifc.sec_ones} + 16'(unused);
  endfunction

  function automatic logic [15:0] shown10(input int unused);
    return {ifc10.min_tens, ifc10.min_ones, ifc10.sec_tens, ifc10.sec_ones} + 16'(unused);
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_rem   = QM * 60;
    m_q     = 1;
    m_buzz  = 0;
    m10     = QM10 * 60;
  endtask

  task automatic model_start();
    case (m_phase)
      P_IDLE:  m_phase = P_RUN;
      P_RUN:   m_phase = P_PAUSE;
      P_PAUSE: m_phase = P_RUN;
      P_BREAK: begin
        m_rem   = QM * 60;
        m_q     = m_q + 1;
        m_phase = P_RUN;
      end
      default: ;
    endcase
  endtask

  task automatic model_tick();
    if (m_phase == P_RUN) begin
      m_rem--;
      if (m_rem == 0) begin
        m_phase = P_BUZZ;
        m_buzz  = 0;
      end
    end else if (m_phase == P_BUZZ) begin
      m_buzz++;
      if (m_buzz == BT) m_phase = (m_q == NQ) ? P_OVER : P_BREAK;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ":time"},      32'(shown(0)),      32'(bcd_of(m_rem)));
    check({tag, ":quarter"},   32'(ifc.quarter),   32'(m_q));
    check({tag, ":running"},   32'(ifc.running),   32'(m_phase == P_RUN));
    check({tag, ":buzzer"},    32'(ifc.buzzer),    32'(m_phase == P_BUZZ));
    check({tag, ":game_over"}, 32'(ifc.game_over), 32'(m_phase == P_OVER));
  endtask

  task automatic drive_tick(input int hi, input int lo);
    @(negedge clk);
    ifc.tick_src = 1'b1;
    repeat (hi) @(negedge clk);
    ifc.tick_src = 1'b0;
    repeat (lo) @(negedge clk);
    model_tick();
  endtask

  task automatic run_ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drive_tick($urandom_range(1, 3), $urandom_range(1, 3));
      check_state(tag);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    ifc.start_pause = 1'b1;
    @(negedge clk);
    ifc.start_pause = 1'b0;
    model_start();
  endtask

  // Start and a fresh tick edge in the same cycle; start wins except in BUZZ.
  task automatic pulse_both();
    @(negedge clk);
    ifc.tick_src    = 1'b1;
    ifc.start_pause = 1'b1;
    @(negedge clk);
    ifc.start_pause = 1'b0;
    @(negedge clk);
    ifc.tick_src = 1'b0;
    @(negedge clk);
    if (m_phase == P_BUZZ) model_tick();
    else                   model_start();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    ifc.start_pause = 1'b0;
    model_reset();
    #1 check_state(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic tick10();
    @(negedge clk);
    ifc10.tick_src = 1'b1;
    @(negedge clk);
    ifc10.tick_src = 1'b0;
    @(negedge clk);
    m10--;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_buzz;
    ifc.tick_src      = 1'b0;
    ifc.start_pause   = 1'b0;
    ifc10.tick_src    = 1'b0;
    ifc10.start_pause = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    check("reset10:time", 32'(shown10(0)), 32'(bcd_of(m10)));
    rst_n = 1'b1;
    @(negedge clk);
    check_state("released");

    // Start, count down to 00:45, pause across ticks, resume.
    pulse_start();
    check_state("start");
    run_ticks(15, "run");
    check("at_0045", 32'(shown(0)), 32'h0045);
    pulse_start();
    check_state("pause");
    run_ticks(5, "paused");
    check("held_0045", 32'(shown(0)), 32'h0045);
    pulse_start();
    check_state("resume");
    run_ticks(1, "resume_tick");
    check("after_resume", 32'(shown(0)), 32'h0044);

    // Start and tick together while running: pause wins, time unchanged.
    pulse_both();
    check_state("both_run");
    check("both_time", 32'(shown(0)), 32'h0044);
    check("both_paused", 32'(ifc.running), 32'd0);
    pulse_both();
    check_state("both_resume");
    check("both_resume_time", 32'(shown(0)), 32'h0044);

    for (int i = 0; i < 100 && m_phase == P_RUN; i++) run_ticks(1, "q1");
    check("q1_zero", 32'(shown(0)), 32'h0000);
    check("q1_buzz_on", 32'(ifc.buzzer), 32'd1);

    n_buzz = 0;
    for (int i = 0; i < 10 && ifc.buzzer; i++) begin
      run_ticks(1, "buzz");
      n_buzz++;
      if (i == 0) begin
        pulse_start();
        check_state("buzz_start_ignored");
      end
    end
    check("buzz_len_ticks", 32'(n_buzz), 32'(BT));
    check("break_quarter", 32'(ifc.quarter), 32'd1);
    check("break_time", 32'(shown(0)), 32'h0000);

    pulse_start();
    check_state("q2_start");
    check("q2_time", 32'(shown(0)), 32'h0100);
    check("q2_quarter", 32'(ifc.quarter), 32'd2);
    for (int i = 0; i < 200 && (m_phase == P_RUN || m_phase == P_BUZZ); i++) run_ticks(1, "q2");
    check("game_over", 32'(ifc.game_over), 32'd1);
    pulse_start();
    run_ticks(2, "over_hold");
    check("over_time", 32'(shown(0)), 32'h0000);
    check("over_quarter", 32'(ifc.quarter), 32'd2);

    // Asynchronous reset at 00:30 of quarter 2 with tick_src held high.
    do_reset("rst_game");
    pulse_start();
    for (int i = 0; i < 200 && m_phase != P_BREAK; i++) run_ticks(1, "rq1");
    pulse_start();
    run_ticks(29, "rq2");
    @(negedge clk);
    ifc.tick_src = 1'b1;
    repeat (2) @(negedge clk);
    model_tick();
    check("rq2_at_0030", 32'(shown(0)), 32'h0030);
    check("rq2_quarter", 32'(ifc.quarter), 32'd2);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_state("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_state("post_release");
    pulse_start();
    repeat (3) @(negedge clk);
    check_state("no_stale_tick");
    check("no_stale_time", 32'(shown(0)), 32'h0100);
    ifc.tick_src = 1'b0;
    run_ticks(1, "first_real_tick");
    check("first_real_time", 32'(shown(0)), 32'h0059);

    // Borrow chain on a 10-minute quarter.
    @(negedge clk);
    ifc10.start_pause = 1'b1;
    @(negedge clk);
    ifc10.start_pause = 1'b0;
    check("b10_running", 32'(ifc10.running), 32'd1);
    check("b10_start", 32'(shown10(0)), 32'h1000);
    tick10();
    check("b10_0959", 32'(shown10(0)), 32'h0959);
    for (int i = 0; i < 59; i++) begin
      tick10();
      check("b10_step", 32'(shown10(0)), 32'(bcd_of(m10)));
    end
    check("b10_0900", 32'(shown10(0)), 32'h0900);
    tick10();
    check("b10_0859", 32'(shown10(0)), 32'h0859);

    // Random interleaving of ticks, start presses and coincident events.
    do_reset("rand_reset");
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 49));
      if (m_phase == P_OVER || r == 0) begin
        do_reset("rand_rst");
      end else if (r < 6) begin
        pulse_start();
        check_state("rand_start");
      end else if (r < 9) begin
        pulse_both();
        check_state("rand_both");
      end else begin
        run_ticks(1, "rand_tick");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_timer_ctrl.md
# game_timer_ctrl

Sequences the scoreboard game clock: converts a slow square wave from the clock divider into one-cycle tick enables and runs the per-quarter countdown. Tracks quarters, handles start/pause, and drives the end-of-quarter buzzer. Sits between the clock divider and the 7-segment display/buzzer logic. Entirely in the `clock_in` domain.

## Interface
- `QUARTER_MIN`, 10: quarter length in minutes; legal range 1..99.
- `NUM_QUARTERS`, 4: quarters per game; legal range 1..7.
- `BUZZ_TICKS`, 3: buzzer duration, counted in ticks.

Clock and reset: one clock, `clock_in`. Reset `reset_n` is asynchronous and active-low.

Ports:
- `clock_in`  in  1  system clock (50 MHz).
- `reset_n`  in  1  asynchronous active-low reset.
- `tick_src`  in  1  slow square wave from the divider, synchronous to `clock_in`; each rising edge is one game-clock tick.
- `start_pause`  in  1  debounced one-cycle button pulse.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  remaining time in BCD.
- `quarter`  out  3  current quarter, 1..NUM_QUARTERS.
- `running`  out  1  high only in RUN.
- `buzzer`  out  1  high only in BUZZ.
- `game_over`  out  1  high only in OVER.

## Operation
Tick generation:
- `tick_q <= tick_src`.
- `tick = tick_src & ~tick_q`.
- `tick_q` resets to 1, so no spurious tick is produced after reset.

FSM states are IDLE, RUN, PAUSE, BUZZ, BREAK, OVER. Reset enters IDLE.
- IDLE: time = QUARTER_MIN:00, quarter = 1. `start_pause` → RUN.
- RUN:
  - `start_pause` → PAUSE. Any tick in the same cycle is discarded, because start has priority.
  - Otherwise, on a tick, decrement the time.
  - If the time was 00:01 before the tick, it becomes 00:00 and the FSM goes to BUZZ.
- PAUSE:
  - Ticks are ignored, but `tick_q` keeps tracking `tick_src`, so no stale tick fires on resume.
  - `start_pause` → RUN.
  - A tick in the resume cycle is not applied.
- BUZZ:
  - Buzz counter loads 0 on entry and increments per tick.
  - On the tick where the counter reaches BUZZ_TICKS-1, go to OVER if quarter == NUM_QUARTERS, else go to BREAK.
  - `start_pause` is ignored.
- BREAK: time shows 00:00. `start_pause` reloads QUARTER_MIN:00, increments `quarter`, and goes to RUN.
- OVER: holds 00:00 and the final quarter. All inputs are ignored until reset.

BCD decrement uses a per-digit borrow chain:
- `sec_ones` 0 → 9, with borrow.
- `sec_tens` 0 → 5, with borrow.
- `min_ones` 0 → 9, with borrow.
- `min_tens` decrements when borrowed into.
- Digits are never outside their legal range.

Load value: `min_tens = QUARTER_MIN/10`, `min_ones = QUARTER_MIN%10`, seconds 0.

## Timing
- Reset values: time = QUARTER_MIN:00, `quarter` = 1, `running` = 0, `buzzer` = 0, `game_over` = 0, state IDLE.
- All outputs are registered.
- A `tick_src` rising edge at clock n asserts `tick` at n+1. The decremented time is visible at n+2.
- `start_pause` at clock n changes state and `running` at n+1.
- `buzzer` rises on the cycle after the 00:01 → 00:00 transition is applied. It stays high for exactly BUZZ_TICKS tick periods.
- Asserting `reset_n` mid-game returns immediately (asynchronously) to the reset values. The first tick after release is not counted unless a new rising edge occurs.

## Structure
- Shared package `placar_pkg`:
  - State encoding localparams: IDLE=0, RUN=1, PAUSE=2, BUZZ=3, BREAK=4, OVER=5.
  - `BCD_W = 4`.
  - Digit limits 9 and 5.
- One sub-module, `tick_pulse`: rising-edge detector with a reset value parameter. It is reusable for other divider taps.
- The BCD borrow chain stays inline.

## Test plan
All scenarios use QUARTER_MIN=1, NUM_QUARTERS=2, BUZZ_TICKS=3.
- Reset, start, 60 ticks → time runs 01:00, 00:59, … 00:00; `buzzer` is high for 3 ticks; FSM ends in BREAK with `quarter` = 1.
- In BREAK, pulse `start_pause` → time 01:00, `quarter` = 2, `running` = 1; after 60+3 more ticks → `game_over` = 1. A further start has no effect.
- Pause at 00:45, issue 5 ticks, then resume → time still 00:45; the first tick after resume gives 00:44.
- `start_pause` and a tick in the same RUN cycle → PAUSE is entered and the time is unchanged.
- Borrow check with QUARTER_MIN=10: 1 tick gives 09:59; 60 ticks give 09:00.
- Assert `reset_n` low at 00:30 of quarter 2 while `tick_src` is high → all reset values appear. With `tick_src` still high after release, no decrement occurs.
